// File: rtl/divider_fp32.sv
// Iterative IEEE-754 single-precision divider, round-to-nearest-even,
// one quotient bit per cycle, STB/BUSY handshake on both sides.
module divider_fp32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        div_input_STB,
  output logic        div_BUSY,
  output logic [31:0] output_div,
  output logic        div_output_STB,
  input  logic        output_module_BUSY
);

  typedef enum logic [3:0] {
    GET_A_AND_B, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B, DIVIDE_0,
    DIVIDE_1, DIVIDE_2, NORMALISE_2, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] EMIN = -10'sd126;
  localparam logic signed [9:0] EMAX = 10'sd127;
  localparam logic signed [9:0] EDEN = -10'sd127;
  localparam logic signed [9:0] ESPC = 10'sd128;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d, out_q, out_d;
  logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic               guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
  logic [50:0]        dvd_q, dvd_d;
  logic [24:0]        rem_q, rem_d, rem_sh_s;
  logic [27:0]        quo_q, quo_d;
  logic [5:0]         cnt_q, cnt_d;
  logic               stb_q, stb_d, busy_q, busy_d;
  logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;

  assign a_nan_s  = (a_e_q == ESPC) && (a_m_q != 24'd0);
  assign b_nan_s  = (b_e_q == ESPC) && (b_m_q != 24'd0);
  assign a_inf_s  = (a_e_q == ESPC) && (a_m_q == 24'd0);
  assign b_inf_s  = (b_e_q == ESPC) && (b_m_q == 24'd0);
  assign a_zero_s = (a_e_q == EDEN) && (a_m_q == 24'd0);
  assign b_zero_s = (b_e_q == EDEN) && (b_m_q == 24'd0);
  // remainder never exceeds the divisor, so its top bit is always clear
  assign rem_sh_s = {rem_q[23:0], dvd_q[50]};

  // Next-state and datapath update for the whole operation sequence.
  always_comb begin
    state_d = state_q;
    a_d = a_q;  b_d = b_q;  z_d = z_q;  out_d = out_q;
    a_m_d = a_m_q;  b_m_d = b_m_q;  z_m_d = z_m_q;
    a_e_d = a_e_q;  b_e_d = b_e_q;  z_e_d = z_e_q;
    a_s_d = a_s_q;  b_s_d = b_s_q;  z_s_d = z_s_q;
    guard_d = guard_q;  round_d = round_q;  sticky_d = sticky_q;
    dvd_d = dvd_q;  rem_d = rem_q;  quo_d = quo_q;  cnt_d = cnt_q;
    stb_d = stb_q;  busy_d = busy_q;
    case (state_q)
      GET_A_AND_B: begin
        busy_d = 1'b0;
        if (!busy_q && div_input_STB) begin
          a_d = input_a;
          b_d = input_b;
          busy_d = 1'b1;
          state_d = UNPACK;
        end else begin
          state_d = GET_A_AND_B;
        end
      end
      UNPACK: begin
        a_m_d = {1'b0, a_q[22:0]};
        b_m_d = {1'b0, b_q[22:0]};
        a_e_d = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        b_e_d = $signed({2'b00, b_q[30:23]}) - 10'sd127;
        a_s_d = a_q[31];
        b_s_d = b_q[31];
        state_d = SPECIAL_CASES;
      end
      SPECIAL_CASES: begin
        state_d = PUT_Z;
        if (a_nan_s || b_nan_s) begin
          z_d = 32'hFFC0_0000;
        end else if ((a_inf_s && b_inf_s) || (a_zero_s && b_zero_s)) begin
          z_d = 32'hFFC0_0000;
        end else if (a_inf_s || b_zero_s) begin
          z_d = {a_s_q ^ b_s_q, 8'hFF, 23'd0};
        end else if (b_inf_s || a_zero_s) begin
          z_d = {a_s_q ^ b_s_q, 31'd0};
        end else begin
          if (a_e_q == EDEN) a_e_d = EMIN; else a_m_d[23] = 1'b1;
          if (b_e_q == EDEN) b_e_d = EMIN; else b_m_d[23] = 1'b1;
          state_d = NORMALISE_A;
        end
      end
      NORMALISE_A: begin
        if (a_m_q[23]) begin
          state_d = NORMALISE_B;
        end else begin
          a_m_d = {a_m_q[22:0], 1'b0};
          a_e_d = a_e_q - 10'sd1;
        end
      end
      NORMALISE_B: begin
        if (b_m_q[23]) begin
          state_d = DIVIDE_0;
        end else begin
          b_m_d = {b_m_q[22:0], 1'b0};
          b_e_d = b_e_q - 10'sd1;
        end
      end
      DIVIDE_0: begin
        z_s_d = a_s_q ^ b_s_q;
        z_e_d = a_e_q - b_e_q;
        dvd_d = {a_m_q, 27'd0};
        rem_d = 25'd0;
        quo_d = 28'd0;
        cnt_d = 6'd0;
        state_d = DIVIDE_1;
      end
      DIVIDE_1: begin
        dvd_d = {dvd_q[49:0], 1'b0};
        if (rem_sh_s >= {1'b0, b_m_q}) begin
          rem_d = rem_sh_s - {1'b0, b_m_q};
          quo_d = {quo_q[26:0], 1'b1};
        end else begin
          rem_d = rem_sh_s;
          quo_d = {quo_q[26:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd50) state_d = DIVIDE_2; else state_d = DIVIDE_1;
      end
      DIVIDE_2: begin
        if (quo_q[27]) begin
          z_m_d = quo_q[27:4];
          guard_d = quo_q[3];
          round_d = quo_q[2];
          sticky_d = quo_q[1] | quo_q[0] | (rem_q != 25'd0);
        end else begin
          z_m_d = quo_q[26:3];
          guard_d = quo_q[2];
          round_d = quo_q[1];
          sticky_d = quo_q[0] | (rem_q != 25'd0);
          z_e_d = z_e_q - 10'sd1;
        end
        state_d = NORMALISE_2;
      end
      NORMALISE_2: begin
        if (z_e_q < EMIN) begin
          z_e_d = z_e_q + 10'sd1;
          z_m_d = {1'b0, z_m_q[23:1]};
          guard_d = z_m_q[0];
          round_d = guard_q;
          sticky_d = sticky_q | round_q;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == 24'hFF_FFFF) z_e_d = z_e_q + 10'sd1; else z_e_d = z_e_q;
        end else begin
          z_m_d = z_m_q;
        end
        state_d = PACK;
      end
      PACK: begin
        z_d = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
        if (z_e_q == EMIN && !z_m_q[23]) z_d[30:23] = 8'd0; else z_d[30:23] = z_e_q[7:0] + 8'd127;
        if (z_e_q > EMAX) z_d = {z_s_q, 8'hFF, 23'd0}; else z_d[31] = z_s_q;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        stb_d = 1'b1;
        out_d = z_q;
        if (stb_q && !output_module_BUSY) begin
          stb_d = 1'b0;
          state_d = GET_A_AND_B;
        end else begin
          state_d = PUT_Z;
        end
      end
      default: begin
        state_d = GET_A_AND_B;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A_AND_B;
      a_q <= 32'd0;  b_q <= 32'd0;  z_q <= 32'd0;  out_q <= 32'd0;
      a_m_q <= 24'd0;  b_m_q <= 24'd0;  z_m_q <= 24'd0;
      a_e_q <= 10'sd0;  b_e_q <= 10'sd0;  z_e_q <= 10'sd0;
      a_s_q <= 1'b0;  b_s_q <= 1'b0;  z_s_q <= 1'b0;
      guard_q <= 1'b0;  round_q <= 1'b0;  sticky_q <= 1'b0;
      dvd_q <= 51'd0;  rem_q <= 25'd0;  quo_q <= 28'd0;  cnt_q <= 6'd0;
      stb_q <= 1'b0;  busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;  b_q <= b_d;  z_q <= z_d;  out_q <= out_d;
      a_m_q <= a_m_d;  b_m_q <= b_m_d;  z_m_q <= z_m_d;
      a_e_q <= a_e_d;  b_e_q <= b_e_d;  z_e_q <= z_e_d;
      a_s_q <= a_s_d;  b_s_q <= b_s_d;  z_s_q <= z_s_d;
      guard_q <= guard_d;  round_q <= round_d;  sticky_q <= sticky_d;
      dvd_q <= dvd_d;  rem_q <= rem_d;  quo_q <= quo_d;  cnt_q <= cnt_d;
      stb_q <= stb_d;  busy_q <= busy_d;
    end
  end

  assign div_BUSY       = busy_q;
  assign div_output_STB = stb_q;
  assign output_div     = out_q;

endmodule

// File: tb/tb_divider_fp32.sv
// Directed self-checking bench for divider_fp32: results, latency, specials,
// range limits, backpressure and mid-division reset.
module tb_divider_fp32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b;
  logic        div_input_STB;
  logic        div_BUSY;
  logic [31:0] output_div;
  logic        div_output_STB;
  logic        output_module_BUSY;

  int checks = 0;
  int errors = 0;

  divider_fp32 dut (
    .clk(clk), .rst(rst), .input_a(input_a), .input_b(input_b),
    .div_input_STB(div_input_STB), .div_BUSY(div_BUSY),
    .output_div(output_div), .div_output_STB(div_output_STB),
    .output_module_BUSY(output_module_BUSY)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (div_BUSY !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(div_BUSY), 32'd0);
  endtask

  // Accept one operand pair and wait for the output strobe.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat, input string tag);
    int n;
    wait_idle(tag);
    input_a = a;
    input_b = b;
    div_input_STB = 1'b1;
    tick();
    div_input_STB = 1'b0;
    chk({tag, "_busy"}, 32'(div_BUSY), 32'd1);
    n = 0;
    while (div_output_STB !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_res"}, output_div, res);
  endtask

  // Transfer with the downstream ready, then expect the idle sequence.
  task automatic finish_op(input logic [31:0] res, input string tag);
    tick();
    chk({tag, "_stb_drop"}, 32'(div_output_STB), 32'd0);
    chk({tag, "_hold_res"}, output_div, res);
    tick();
    chk({tag, "_busy_drop"}, 32'(div_BUSY), 32'd0);
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] res, input int lat, input string tag);
    run_op(a, b, res, lat, tag);
    finish_op(res, tag);
  endtask

  initial begin
    rst = 1'b1;
    input_a = 32'd0;
    input_b = 32'd0;
    div_input_STB = 1'b0;
    output_module_BUSY = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(div_BUSY), 32'd0);
    chk("rst_stb", 32'(div_output_STB), 32'd0);
    chk("rst_out", output_div, 32'd0);

    op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 61, "six_div_two");
    op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 61, "one_third");
    op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 61, "one_one");

    op(32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 3, "div_neg_zero");
    op(32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 3, "zero_zero");
    op(32'h7F80_0000, 32'h7F80_0000, 32'hFFC0_0000, 3, "inf_inf");
    op(32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 3, "two_inf");
    op(32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, 3, "nan_one");

    op(32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 62, "denorm_res");
    op(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 61, "overflow");
    op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, 107, "denorm_in");

    // Downstream stalls for 20 cycles while stray strobes arrive.
    output_module_BUSY = 1'b1;
    run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 61, "bp");
    for (int i = 0; i < 20; i++) begin
      input_a = 32'h4000_0000;
      input_b = 32'h3F80_0000;
      div_input_STB = (i % 3 == 0);
      tick();
      div_input_STB = 1'b0;
      chk("bp_out", output_div, 32'h3EAA_AAAB);
      chk("bp_stb", 32'(div_output_STB), 32'd1);
      chk("bp_busy", 32'(div_BUSY), 32'd1);
    end
    output_module_BUSY = 1'b0;
    finish_op(32'h3EAA_AAAB, "bp");
    op(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 61, "after_bp");

    // Reset lands on divide iteration 20 of a 1/3 operation.
    wait_idle("mid_rst");
    input_a = 32'h3F80_0000;
    input_b = 32'h4040_0000;
    div_input_STB = 1'b1;
    tick();
    div_input_STB = 1'b0;
    repeat (25) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(div_BUSY), 32'd0);
    chk("mid_rst_stb", 32'(div_output_STB), 32'd0);
    chk("mid_rst_out", output_div, 32'd0);
    op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 61, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
